// File: rtl/spi_slave_ctrl_pkg.sv
// Shared types and constants for the SPI slave protocol controller:
// FSM state encoding, default frame widths and frame opcodes.
package spi_ctrl_pkg;

  localparam int SPI_RX_WIDTH = 10;
  localparam int SPI_TX_WIDTH = 8;

  // Opcode carried in rx_data[9:8]
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Pin-side and memory-side signals of the SPI slave controller.
// slave modport: the controller; master modport: whatever drives the pins
// and the memory reply (SPI master plus RAM model).
interface spi_slave_ctrl_if #(
  parameter int RX_WIDTH = 10,
  parameter int TX_WIDTH = 8
) ();

  logic                SS_n;
  logic                MOSI;
  logic                MISO;
  logic [RX_WIDTH-1:0] rx_data;
  logic                rx_valid;
  logic [TX_WIDTH-1:0] tx_data;
  logic                tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_slave_ctrl_tx_shifter.sv
// MISO reply shifter: loads a TX_WIDTH-bit reply, presents it MSB first on a
// registered MISO, one bit per clock, then returns MISO to 0. An abort clears
// everything so MISO is 0 on the following cycle.
module spi_tx_shifter #(
  parameter int TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [TX_WIDTH-1:0] data_i,
  input  logic                abort_i,
  output logic                miso_o,
  output logic                mid_reply_o
);

  localparam int CNT_W = $clog2(TX_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TX_WIDTH);

  // cnt_q = number of reply bits placed on MISO so far (0..TX_WIDTH)
  logic [TX_WIDTH-1:0] sr_q,   sr_d;
  logic [CNT_W-1:0]    cnt_q,  cnt_d;
  logic                busy_q, busy_d;
  logic                miso_q, miso_d;

  // Next-state: abort wins, then load, then shift out remaining bits
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    miso_d = 1'b0;
    if (abort_i) begin
      sr_d   = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (load_i) begin
      sr_d   = data_i << 1;
      miso_d = data_i[TX_WIDTH-1];
      cnt_d  = CNT_W'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q < CNT_FULL) begin
        miso_d = sr_q[TX_WIDTH-1];
        sr_d   = sr_q << 1;
        cnt_d  = cnt_q + CNT_W'(1);
      end else begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end
    end
  end

  // Shifter state and registered MISO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      miso_q <= miso_d;
    end
  end

  assign miso_o      = miso_q;
  // Reply started but not all bits have completed their cycle on MISO
  assign mid_reply_o = busy_q && (cnt_q < CNT_FULL);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave protocol controller: decodes the command bit, collects frames
// into rx_data, tracks the read-address/read-data phase and launches the
// MISO reply once memory returns tx_data.
// Optional feature macro: SPI_CTRL_FRAME_ERR_EN adds the frame_err output,
// a one-cycle pulse when SS_n ends a frame or a reply prematurely.
module spi_slave_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int RX_WIDTH = SPI_RX_WIDTH,
  parameter int TX_WIDTH = SPI_TX_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_slave_ctrl_if.slave bus
`ifdef SPI_CTRL_FRAME_ERR_EN
  ,
  output logic            frame_err
`endif
);

  localparam int CNT_W = $clog2(RX_WIDTH);
  // bit_cnt_q counts payload bits after the command bit; the edge seen with
  // CNT_LAST captures bit 0, and CNT_DONE marks a finished frame.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RX_WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(RX_WIDTH - 1);

  spi_state_t          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [RX_WIDTH-2:0] shift_q, shift_d;
  logic [RX_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_addr_done_q, rd_addr_done_d;
  logic                awaiting_q, awaiting_d;
  logic                in_frame;
  logic                tx_load;
  logic                tx_abort;
  logic                tx_miso;
  logic                tx_mid_reply;

  assign in_frame = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);

  // Next-state and datapath decode for the frame FSM
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    awaiting_d     = awaiting_q;
    tx_load        = 1'b0;
    tx_abort       = bus.SS_n && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!bus.SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        bit_cnt_d = '0;
        shift_d   = {{(RX_WIDTH-2){1'b0}}, bus.MOSI};
        if (bus.SS_n)           state_d = IDLE;
        else if (!bus.MOSI)     state_d = WRITE;
        else if (!rd_addr_done_q) state_d = READ_ADD;
        else                    state_d = READ_DATA;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bit_cnt_q < CNT_DONE) begin
          shift_d   = {shift_q[RX_WIDTH-3:0], bus.MOSI};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_LAST) begin
            // Completing edge: frame counts even if SS_n rises right here
            rx_data_d  = {shift_q, bus.MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
            if (state_q == READ_DATA) begin
              rd_addr_done_d = 1'b0;
              awaiting_d     = 1'b1;
            end
          end
        end else if ((state_q == READ_DATA) && awaiting_q && bus.tx_valid &&
                     !bus.SS_n && !tx_mid_reply) begin
          tx_load    = 1'b1;
          awaiting_d = 1'b0;
        end
        if (bus.SS_n) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          awaiting_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // FSM, frame collection and read-phase tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      awaiting_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      awaiting_q     <= awaiting_d;
    end
  end

  spi_tx_shifter #(
    .TX_WIDTH (TX_WIDTH)
  ) u_tx_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (tx_load),
    .data_i      (bus.tx_data),
    .abort_i     (tx_abort),
    .miso_o      (tx_miso),
    .mid_reply_o (tx_mid_reply)
  );

  assign bus.MISO     = tx_miso;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

`ifdef SPI_CTRL_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  // Flag SS_n rising on an unfinished frame or an unfinished reply
  always_comb begin
    frame_err_d = 1'b0;
    if (bus.SS_n) begin
      if (state_q == CHK_CMD)                          frame_err_d = 1'b1;
      else if (in_frame && (bit_cnt_q < CNT_LAST))     frame_err_d = 1'b1;
      else if ((state_q == READ_DATA) && tx_mid_reply) frame_err_d = 1'b1;
    end
  end

  // One-cycle frame_err pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`else
  logic unused_in_frame;
  assign unused_in_frame = in_frame;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: stimulus pushes expected rx frames,
// MISO values and frame_err pulses (tagged with the clock count) into queues;
// a negedge monitor pops and compares when the DUT presents them.
module tb_spi_slave_ctrl;
  import spi_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_ctrl_if #(.RX_WIDTH(10), .TX_WIDTH(8)) bus ();

`ifdef SPI_CTRL_FRAME_ERR_EN
  logic frame_err;
`endif

  spi_slave_ctrl #(.RX_WIDTH(10), .TX_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SPI_CTRL_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  typedef struct { int cyc; logic [9:0] data; } rx_exp_t;
  typedef struct { int cyc; logic v; } miso_exp_t;

  rx_exp_t   rx_q[$];
  miso_exp_t miso_q[$];
  int        err_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_rx(input int c, input logic [9:0] d);
    rx_exp_t t;
    t.cyc = c; t.data = d;
    rx_q.push_back(t);
  endtask

  task automatic exp_miso(input int c, input logic v);
    miso_exp_t t;
    t.cyc = c; t.v = v;
    miso_q.push_back(t);
  endtask

  task automatic step(input logic ss, input logic mosi);
    bus.SS_n = ss;
    bus.MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  // One SS_n-high cycle, then a full frame; state checked after the command bit.
  task automatic frame(input logic [9:0] f, input spi_state_t exp_st, input logic last_ss);
    exp_miso(cyc + 1, 1'b0);
    step(1'b1, 1'b0);
    exp_miso(cyc + 1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) begin
      exp_miso(cyc + 1, 1'b0);
      if (i == 0) exp_rx(cyc + 1, f);
      step((i == 0) ? last_ss : 1'b0, f[i]);
      if (i == 9) check("state_after_cmd", dut.state_q, exp_st);
    end
  endtask

  rx_exp_t   mon_rx;
  miso_exp_t mon_miso;
  int        mon_err;

  // Monitor: compare whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid) begin
        if (rx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected: rx_valid=1 rx_data=%0h at cycle %0d, required no strobe", bus.rx_data, cyc);
        end else begin
          mon_rx = rx_q.pop_front();
          check("rx_cycle", cyc, mon_rx.cyc);
          check("rx_data", bus.rx_data, mon_rx.data);
        end
      end
      if (miso_q.size() > 0 && miso_q[0].cyc == cyc) begin
        mon_miso = miso_q.pop_front();
        check("miso", bus.MISO, mon_miso.v);
      end
`ifdef SPI_CTRL_FRAME_ERR_EN
      if (frame_err) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_err_unexpected: pulse at cycle %0d, required none", cyc);
        end else begin
          mon_err = err_q.pop_front();
          check("frame_err_cycle", cyc, mon_err);
        end
      end
`endif
    end
  end

  initial begin
    logic [7:0] d;
    int base;
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    #12;
    check("reset_miso", bus.MISO, 0);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_state", dut.state_q, IDLE);
`ifdef SPI_CTRL_FRAME_ERR_EN
    check("reset_frame_err", frame_err, 0);
`endif
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Write address; tx_valid held high must not start a reply
    bus.tx_valid = 1'b1; bus.tx_data = 8'hFF;
    frame(10'h0A5, WRITE, 1'b0);
    bus.tx_valid = 1'b0;

    // Read address then read data, reply B6, later tx_valid ignored
    frame(10'h23C, READ_ADD, 1'b0);
    frame(10'h3C7, READ_DATA, 1'b0);
    d = 8'hB6;
    bus.tx_valid = 1'b1; bus.tx_data = d;
    base = cyc + 1;
    for (int i = 0; i < 8; i++) exp_miso(base + i, d[7-i]);
    exp_miso(base + 8, 1'b0);
    exp_miso(base + 9, 1'b0);
    step(1'b0, 1'b0);
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    bus.tx_valid = 1'b1; bus.tx_data = 8'hFF;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    bus.tx_valid = 1'b0;

    // Abort after 5 payload bits, then a clean write-data frame
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
`ifdef SPI_CTRL_FRAME_ERR_EN
    err_q.push_back(cyc + 1);
`endif
    step(1'b1, 1'b1);
    check("abort_state_idle", dut.state_q, IDLE);
    frame(10'h15A, WRITE, 1'b0);

    // SS_n rising on the bit-0 edge still completes the frame
    frame(10'h1C3, WRITE, 1'b1);
    check("same_edge_idle", dut.state_q, IDLE);

    // Abort mid-reply after 3 MISO bits
    frame(10'h2AA, READ_ADD, 1'b0);
    frame(10'h3AA, READ_DATA, 1'b0);
    bus.tx_valid = 1'b1; bus.tx_data = 8'hE5;
    base = cyc + 1;
    exp_miso(base, 1'b1);
    exp_miso(base + 1, 1'b1);
    exp_miso(base + 2, 1'b1);
    exp_miso(base + 3, 1'b0);
    exp_miso(base + 4, 1'b0);
    step(1'b0, 1'b0);
    bus.tx_valid = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
`ifdef SPI_CTRL_FRAME_ERR_EN
    err_q.push_back(cyc + 1);
`endif
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    // rd_addr_done was cleared by the read-data frame: next read is an address
    frame(10'h355, READ_ADD, 1'b0);
    bus.tx_valid = 1'b1; bus.tx_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      exp_miso(cyc + 1, 1'b0);
      step(1'b0, 1'b0);
    end
    bus.tx_valid = 1'b0;

    // Asynchronous reset in the middle of a reply
    frame(10'h3F0, READ_DATA, 1'b0);
    bus.tx_valid = 1'b1; bus.tx_data = 8'hC3;
    base = cyc + 1;
    exp_miso(base, 1'b1);
    exp_miso(base + 1, 1'b1);
    step(1'b0, 1'b0);
    bus.tx_valid = 1'b0;
    step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_miso", bus.MISO, 0);
    check("async_rst_rx_data", bus.rx_data, 0);
    check("async_rst_rx_valid", bus.rx_valid, 0);
    check("async_rst_state", dut.state_q, IDLE);
    #1;
    rst_n = 1'b1;
    frame(10'h3C0, READ_ADD, 1'b0);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rx_queue_drained", rx_q.size(), 0);
    check("miso_queue_drained", miso_q.size(), 0);
`ifdef SPI_CTRL_FRAME_ERR_EN
    check("frame_err_queue_drained", err_q.size(), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave protocol controller that sequences the receive (serial-to-parallel) and transmit (parallel-to-serial) paths of the SPI slave. It decodes the command bit at frame start, collects 10-bit frames into `rx_data`, tracks the read-address/read-data phase, and launches the 8-bit MISO reply when the attached memory returns `tx_data`. It sits between the SPI pins and the slave's RAM interface.

## Interface
- `RX_WIDTH`, default 10: received frame width (2-bit opcode + 8-bit payload).
- `TX_WIDTH`, default 8: transmit reply width.
- `clk`  in  1  SPI clock; all logic on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `SS_n`  in  1  slave select, active low; frame boundary.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first; registered.
- `rx_data`  out  RX_WIDTH  last complete frame; `[9:8]` opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
- `rx_valid`  out  1  one-cycle strobe, `rx_data` valid.
- `tx_data`  in  TX_WIDTH  read reply from memory.
- `tx_valid`  in  1  `tx_data` valid; sampled only while awaiting reply.
- One clock, `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: posedge with `SS_n`=0 -> CHK_CMD.
- CHK_CMD: sample MOSI as frame bit 9 and branch: 0 -> WRITE; 1 with `rd_addr_done`=0 -> READ_ADD; 1 with `rd_addr_done`=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift in 9 more bits, MSB first. On the posedge capturing bit 0, load `rx_data` and assert `rx_valid` for exactly one cycle. Further MOSI bits are ignored until `SS_n` rises.
- `rd_addr_done` is internal and reset to 0. It is set when a READ_ADD frame completes and cleared when a READ_DATA frame completes.
- READ_DATA after `rx_valid`: wait for `tx_valid`. On the first posedge with `tx_valid`=1, latch `tx_data`. MISO then presents `tx_data[7]` through `tx_data[0]` on 8 consecutive cycles, starting the cycle after the latch. After that, MISO=0 and `tx_valid` is ignored.
- `SS_n`=1 at any posedge while not IDLE:
  - go to IDLE;
  - clear the bit and tx counters;
  - drop any partial frame (no `rx_valid`);
  - MISO=0 on the next cycle;
  - leave `rd_addr_done` unchanged.
- `SS_n`=1 on the same posedge as the bit-0 capture: the frame is complete, so `rx_valid` asserts, then go to IDLE.

## Timing
- Reset values: `MISO`=0, `rx_data`=0, `rx_valid`=0, state IDLE, `rd_addr_done`=0, counters 0.
- `SS_n` fall to `rx_valid`: 1 (IDLE) + 1 (CHK_CMD) + 9 = 11 posedges.
- `tx_valid` sample to MISO bit 7: 1 cycle. Reply duration is 8 cycles.
- MISO is 0 whenever no reply is being shifted.
- Bit counter is 4 bits and counts 0..9 with no wrap inside a frame. Tx counter counts 0..8.

## Configuration
- `SPI_CTRL_FRAME_ERR_EN` defined: adds output `frame_err` (1 bit, reset 0). It pulses for one cycle on the posedge where `SS_n` is sampled high in either case:
  - in CHK_CMD, or after 1–8 payload bits (partial frame);
  - in READ_DATA with a reply latched but fewer than 8 bits shifted.
- `SPI_CTRL_FRAME_ERR_EN` undefined: the port and its logic are absent; abort behaviour is otherwise identical.

## Structure
- Package `spi_ctrl_pkg`:
  - state enum `spi_state_t`;
  - `RX_WIDTH`/`TX_WIDTH` defaults;
  - opcode constants `OP_WR_ADDR`, `OP_WR_DATA`, `OP_RD_ADDR`, `OP_RD_DATA`.
- Sub-module `spi_tx_shifter`: a load/shift register with an 8-count counter, a `busy` flag and registered MISO.

## Test plan
- Write address: `SS_n` low, MOSI 0,0,1010_0101 -> `rx_valid` at posedge 11, `rx_data`=10'h0A5, FSM passes through WRITE, MISO stays 0.
- Read sequence:
  - frame 10,0x3C -> `rx_data`=10'h23C, `rd_addr_done`=1;
  - next frame 11,xx -> READ_DATA, `rx_valid`;
  - `tx_valid` with `tx_data`=8'hB6 -> MISO 1,0,1,1,0,1,1,0 on the next 8 cycles, then 0.
- Abort: `SS_n` rises after 5 payload bits -> no `rx_valid`, IDLE next cycle, `frame_err` pulse (macro on); the next full frame decodes correctly.
- `SS_n` rises mid-reply after 3 MISO bits -> MISO=0 next cycle, `rd_addr_done` stays 0, `frame_err` pulses (macro on).
- Asynchronous reset asserted mid-READ_DATA -> all outputs 0 immediately; after release, a first read frame goes to READ_ADD.
- Without `SPI_CTRL_FRAME_ERR_EN`: no `frame_err` port, and the abort scenarios give the same `rx_valid`/MISO behaviour.
